// File: rtl/anti_theft_controller.sv
// Car anti-theft alarm sequencer: tracks doors, ignition and the hidden switch, selects the
// active delay interval, and times it with an internal prescaler and 4-bit countdown.
module anti_theft_controller #(
    parameter int CLKS_PER_TICK = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       hidden_sw,
    input  logic       reprogram,
    input  logic [3:0] param_value,
    output logic [1:0] interval,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_dbg
);

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_TICK - 1);

    localparam logic [1:0] IV_ARM_DELAY  = 2'b00;
    localparam logic [1:0] IV_DRIVER     = 2'b01;
    localparam logic [1:0] IV_PASSENGER  = 2'b10;
    localparam logic [1:0] IV_ALARM_ON   = 2'b11;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'b000,
        ST_TRIGGERED  = 3'b001,
        ST_SOUND      = 3'b010,
        ST_DISARMED   = 3'b011,
        ST_WAIT_OPEN  = 3'b100,
        ST_WAIT_CLOSE = 3'b101,
        ST_ARM_DLY    = 3'b110
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    interval_nxt;
    logic          load_nxt;
    logic          load_pending;
    logic [3:0]    count;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          expire;
    logic          disarm_req;
    logic          any_door;
    logic          nxt_timed;

    function automatic logic is_timed(input state_t s);
        return (s == ST_TRIGGERED) || (s == ST_SOUND) || (s == ST_ARM_DLY);
    endfunction

    // A freshly loaded count is not valid until the cycle after entry, hence the load_pending gate.
    assign tick       = (prescaler == PRE_MAX);
    assign expire     = tick && (count <= 4'd1) && !load_pending;
    assign disarm_req = ignition && hidden_sw;
    assign any_door   = door_driver || door_pass;
    assign nxt_timed  = is_timed(state_nxt);
    assign state_dbg  = state;

    always_comb begin
        state_nxt    = state;
        interval_nxt = interval;
        load_nxt     = 1'b0;
        if (reprogram) begin
            state_nxt = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (door_driver) begin
                        state_nxt    = ST_TRIGGERED;
                        interval_nxt = IV_DRIVER;
                        load_nxt     = 1'b1;
                    end else if (door_pass) begin
                        state_nxt    = ST_TRIGGERED;
                        interval_nxt = IV_PASSENGER;
                        load_nxt     = 1'b1;
                    end
                end
                ST_TRIGGERED: begin
                    if (disarm_req) begin
                        state_nxt = ST_DISARMED;
                    end else if (expire) begin
                        state_nxt    = ST_SOUND;
                        interval_nxt = IV_ALARM_ON;
                        load_nxt     = 1'b1;
                    end
                end
                ST_SOUND: begin
                    if (disarm_req) begin
                        state_nxt = ST_DISARMED;
                    end else if (expire) begin
                        if (any_door) begin
                            interval_nxt = IV_ALARM_ON;
                            load_nxt     = 1'b1;
                        end else begin
                            state_nxt = ST_ARMED;
                        end
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) state_nxt = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (ignition)         state_nxt = ST_DISARMED;
                    else if (door_driver) state_nxt = ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    if (ignition) begin
                        state_nxt = ST_DISARMED;
                    end else if (!door_driver) begin
                        state_nxt    = ST_ARM_DLY;
                        interval_nxt = IV_ARM_DELAY;
                        load_nxt     = 1'b1;
                    end
                end
                ST_ARM_DLY: begin
                    if (ignition)      state_nxt = ST_DISARMED;
                    else if (any_door) state_nxt = ST_WAIT_CLOSE;
                    else if (expire)   state_nxt = ST_ARMED;
                end
                default: state_nxt = ST_ARMED;
            endcase
        end
    end

    // Prescaler also runs in ARMED to pace the status LED blink.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_ARMED;
            interval     <= IV_ARM_DELAY;
            siren        <= 1'b0;
            status_led   <= 1'b0;
            count        <= 4'd0;
            prescaler    <= '0;
            load_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            interval     <= interval_nxt;
            load_pending <= load_nxt;
            siren        <= (state_nxt == ST_SOUND);

            if (state_nxt == ST_ARMED)
                status_led <= (state == ST_ARMED && !reprogram) ? (status_led ^ tick) : 1'b0;
            else
                status_led <= (state_nxt == ST_TRIGGERED) || (state_nxt == ST_SOUND);

            if (reprogram || !(nxt_timed || state_nxt == ST_ARMED) || load_pending || tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;

            if (reprogram || !nxt_timed)
                count <= 4'd0;
            else if (load_pending)
                count <= param_value;
            else if (tick && count != 4'd0)
                count <= count - 4'd1;
        end
    end

endmodule
